// File: rtl/ro_meas_pkg.sv
// Shared types and default constants for the ring-oscillator measurement block.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DONE
    } state_t;

    localparam int DEF_WINDOW_W      = 16;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with a one-cycle
// rising-edge pulse taken from the last stage.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement controller: enable, settle, count tap edges
// over a programmable window, then hand the result out via valid/ready.
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int WINDOW_W      = DEF_WINDOW_W,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic                ro_tap,
    output logic                ro_en,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CNT_W-1:0]    res_count,
    output logic                res_ovf
);

    localparam logic [WINDOW_W-1:0] SETTLE_LOAD = WINDOW_W'(SETTLE_CYCLES - 1);

    state_t              state, state_nxt;
    logic [WINDOW_W-1:0] timer;
    logic [WINDOW_W-1:0] win;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                ovf, ovf_nxt;
    logic                edge_p;
    logic                tmr_zero;
    logic                cnt_sat;

    sync_edge_det #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (ro_tap),
        .rise(edge_p)
    );

    assign tmr_zero = (timer == '0);
    assign cnt_sat  = &cnt;
    assign cnt_nxt  = (edge_p && !cnt_sat) ? cnt + 1'b1 : cnt;
    assign ovf_nxt  = ovf | (edge_p & cnt_sat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ro_en     = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && window_len != '0) state_nxt = SETTLE;
            end
            SETTLE: begin
                ro_en = 1'b1;
                if (abort)         state_nxt = IDLE;
                else if (tmr_zero) state_nxt = MEASURE;
            end
            MEASURE: begin
                ro_en = 1'b1;
                if (abort)         state_nxt = IDLE;
                else if (tmr_zero) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers only load on a completed window, so an abort
    // leaves the previous result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer     <= '0;
            win       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (state_nxt == SETTLE) begin
                        win   <= window_len;
                        timer <= SETTLE_LOAD;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                SETTLE: begin
                    timer <= tmr_zero ? win - 1'b1 : timer - 1'b1;
                end
                MEASURE: begin
                    cnt   <= cnt_nxt;
                    ovf   <= ovf_nxt;
                    timer <= timer - 1'b1;
                    if (state_nxt == DONE) begin
                        res_count <= cnt_nxt;
                        res_ovf   <= ovf_nxt;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
Measurement controller for the on-chip ring oscillator. It enables the oscillator, waits a fixed settle time, then counts rising edges of one oscillator tap over a programmable window of system clocks. The result is presented through a valid/ready handshake. It sits between the input-switch/host logic and the ring oscillator, and owns the oscillator's enable line.

Parameters:
WINDOW_W, 16, width of the window-length input (measurement cycles)
CNT_W, 16, width of the edge counter and result
SETTLE_CYCLES, 8, clk cycles the oscillator runs before counting starts (≥1)
SYNC_STAGES, 2, flops in the tap synchronizer (≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request to begin a measurement
abort  in  1  cancel a measurement in progress
window_len  in  WINDOW_W  measurement window in clk cycles; sampled on accepted start
ro_tap  in  1  asynchronous oscillator tap (divided externally below clk/2)
ro_en  out  1  ring-oscillator enable
busy  out  1  high in any state other than IDLE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_count  out  CNT_W  rising edges counted in the window
res_ovf  out  1  counter saturated during the window

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - ro_en, busy, res_valid, res_count and res_ovf are all 0.
  - Synchronizer and edge-detect flops are cleared to 0.
  - Reset wins over every other input, in every state.
- Edge detection:
  - ro_tap passes through SYNC_STAGES flops.
  - A rising edge is a cycle where the last synchronizer stage is 1 and the previous sample was 0.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - start=1 and window_len≠0: latch window_len, clear the counter and overflow flag, go to SETTLE.
  - ro_en rises in the next cycle.
  - start with window_len=0 is ignored: stay in IDLE, no outputs change.
- SETTLE:
  - ro_en=1 for exactly SETTLE_CYCLES cycles; edges are not counted.
  - Then go to MEASURE.
- MEASURE:
  - ro_en=1 for exactly the latched window_len cycles.
  - Each detected edge increments the counter.
  - At all-ones the counter holds and res_ovf sets sticky.
  - After the last cycle go to DONE.
- DONE:
  - ro_en=0.
  - res_valid=1, with res_count and res_ovf stable until the handshake.
  - res_valid & res_ready → IDLE next cycle; res_valid drops.
  - res_valid is never withdrawn without res_ready.
- Latency: start accepted at cycle 0 → ro_en=1 from cycle 1 → res_valid=1 at cycle 1+SETTLE_CYCLES+window_len.
- start outside IDLE: ignored, including in the same cycle as the res_ready handshake.
- abort:
  - In SETTLE or MEASURE: go to IDLE next cycle, ro_en=0, no result produced, previous res_count retained.
  - In IDLE or DONE: ignored.
- start and abort together in IDLE: start wins.

Decomposition:
- Package ro_meas_pkg holds:
  - state enum (IDLE, SETTLE, MEASURE, DONE)
  - default parameter constants
- Sub-module sync_edge_det:
  - parameterised SYNC_STAGES synchronizer plus rising-edge pulse output
  - reused for any async tap

Test Plan:
- window_len=64, ro_tap square wave period 8 clks → ro_en high from cycle 1; res_valid at cycle 1+8+64=73; res_count=8, res_ovf=0.
- CNT_W=4, window_len=200, tap period 4 → res_count=15, res_ovf=1.
- Backpressure: res_ready low 10 cycles after res_valid → res_valid and res_count held constant; start pulses during this time are ignored; res_ready=1 → IDLE next cycle, busy=0.
- abort in MEASURE cycle 20 of 64 → ro_en=0 and busy=0 next cycle; res_valid never asserts; res_count keeps its prior value.
- start with window_len=0 → busy stays 0, ro_en stays 0.
- rst=1 mid-MEASURE → all outputs 0 next cycle; a new start afterwards gives a correct count (8 for period 8, window 64).
